// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter sequencer for INC/JMP/BRANCH/vector fetch; PC_BRANCH_PAGE_PENALTY_EN adds the BR_FIX cycle on page-crossing branches
module pc_sequencer (
    input  logic        fclk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd,
    output logic        cmd_ready,
    input  logic [7:0]  db_in,
    output logic [15:0] pc_out,
    output logic [15:0] addr_out,
    output logic        done
);
`ifdef PC_BRANCH_PAGE_PENALTY_EN
    typedef enum logic [2:0] {IDLE, LOAD_LO, LOAD_HI, VEC_LO, VEC_HI, BR_FIX} state_t;
    logic [7:0] hi_q, hi_d;
`else
    typedef enum logic [2:0] {IDLE, LOAD_LO, LOAD_HI, VEC_LO, VEC_HI} state_t;
`endif
    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] vec_q, vec_d;
    logic [7:0]  lo_q, lo_d;
    logic        done_q, done_d;
    logic [15:0] target;
    assign target    = pc_q + {{8{db_in[7]}}, db_in};
    assign cmd_ready = (state_q == IDLE) && !reset;
    assign pc_out    = pc_q;
    assign done      = done_q;
    assign addr_out  = (state_q == VEC_LO) ? vec_q : (state_q == VEC_HI) ? vec_q + 16'd1 : pc_q;
    // next-state and pc update; the pc only changes on the final edge of multi-byte loads
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        vec_d   = vec_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
`ifdef PC_BRANCH_PAGE_PENALTY_EN
        hi_d    = hi_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd)
                        3'd1: begin
                            pc_d   = pc_q + 16'd1;
                            done_d = 1'b1;
                        end
                        3'd2: state_d = LOAD_LO;
                        3'd3: begin
`ifdef PC_BRANCH_PAGE_PENALTY_EN
                            if (target[15:8] != pc_q[15:8]) begin
                                pc_d    = {pc_q[15:8], target[7:0]};
                                hi_d    = target[15:8];
                                state_d = BR_FIX;
                            end else begin
                                pc_d   = target;
                                done_d = 1'b1;
                            end
`else
                            pc_d   = target;
                            done_d = 1'b1;
`endif
                        end
                        3'd4: begin
                            vec_d   = 16'hFFFC;
                            state_d = VEC_LO;
                        end
                        3'd5: begin
                            vec_d   = 16'hFFFA;
                            state_d = VEC_LO;
                        end
                        3'd6: begin
                            vec_d   = 16'hFFFE;
                            state_d = VEC_LO;
                        end
                        default: ;
                    endcase
                end
            end
            LOAD_LO: begin
                lo_d    = db_in;
                state_d = LOAD_HI;
            end
            VEC_LO: begin
                lo_d    = db_in;
                state_d = VEC_HI;
            end
            LOAD_HI, VEC_HI: begin
                pc_d    = {db_in, lo_q};
                done_d  = 1'b1;
                state_d = IDLE;
            end
`ifdef PC_BRANCH_PAGE_PENALTY_EN
            BR_FIX: begin
                pc_d    = {hi_q, pc_q[7:0]};
                done_d  = 1'b1;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end
    // state registers; reset aborts any command in flight
    always_ff @(posedge fclk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= 16'h0000;
            vec_q   <= 16'h0000;
            lo_q    <= 8'h00;
            done_q  <= 1'b0;
`ifdef PC_BRANCH_PAGE_PENALTY_EN
            hi_q    <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            vec_q   <= vec_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
`ifdef PC_BRANCH_PAGE_PENALTY_EN
            hi_q    <= hi_d;
`endif
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized transaction-level check of pc_sequencer against a behavioural model
module tb_pc_sequencer;
`ifdef PC_BRANCH_PAGE_PENALTY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif
    logic        fclk, reset, cmd_valid, cmd_ready, done;
    logic [2:0]  cmd;
    logic [7:0]  db_in;
    logic [15:0] pc_out, addr_out;
    logic [15:0] m_pc, m_addr_val;
    logic        m_idle, m_done, m_addr_ovr, chk_en;
    int          n_pass, n_tot;

    pc_sequencer dut (
        .fclk(fclk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_ready(cmd_ready), .db_in(db_in), .pc_out(pc_out),
        .addr_out(addr_out), .done(done)
    );

    initial begin
        fclk = 1'b0;
        forever #5 fclk = ~fclk;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    // every cycle: compare DUT outputs with the model's view of the current cycle
    always @(negedge fclk) begin
        if (chk_en) begin
            chk("pc_out", pc_out, m_pc);
            chk("done", {15'd0, done}, {15'd0, m_done});
            chk("cmd_ready", {15'd0, cmd_ready}, {15'd0, m_idle && !reset});
            chk("addr_out", addr_out, m_addr_ovr ? m_addr_val : m_pc);
        end
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction
    function automatic logic [2:0] rc();
        return 3'($urandom_range(0, 7));
    endfunction
    function automatic logic [7:0] rd();
        return 8'($urandom);
    endfunction

    task automatic cyc(input logic v, input logic [2:0] c, input logic [7:0] d, input logic r);
        reset = r;
        cmd_valid = v;
        cmd = c;
        db_in = d;
        @(posedge fclk);
        #1;
        m_done = 1'b0;
        m_addr_ovr = 1'b0;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(rb(), rc(), rd(), 1'b1);
            m_pc = 16'h0000;
            m_idle = 1'b1;
        end
        reset = 1'b0;
        cmd_valid = 1'b0;
        #1;
        chk("ready_after_reset", {15'd0, cmd_ready}, 16'd1);
    endtask

    task automatic do_nop(input logic [2:0] c);
        cyc(1'b1, c, rd(), 1'b0);
    endtask

    task automatic do_inc();
        cyc(1'b1, 3'd1, rd(), 1'b0);
        m_pc = m_pc + 16'd1;
        m_done = 1'b1;
    endtask

    task automatic do_jmp(input logic [7:0] lo, input logic [7:0] hi);
        cyc(1'b1, 3'd2, rd(), 1'b0);
        m_idle = 1'b0;
        cyc(rb(), rc(), lo, 1'b0);
        cyc(rb(), rc(), hi, 1'b0);
        m_pc = {hi, lo};
        m_done = 1'b1;
        m_idle = 1'b1;
    endtask

    task automatic do_vec(input logic [2:0] c, input logic [7:0] lo, input logic [7:0] hi, input logic abort);
        logic [15:0] base;
        base = (c == 3'd4) ? 16'hFFFC : (c == 3'd5) ? 16'hFFFA : 16'hFFFE;
        cyc(1'b1, c, rd(), 1'b0);
        m_idle = 1'b0;
        m_addr_ovr = 1'b1;
        m_addr_val = base;
        cyc(1'b1, 3'd1, lo, 1'b0);
        m_addr_ovr = 1'b1;
        m_addr_val = base + 16'd1;
        cyc(1'b1, 3'd1, hi, abort);
        m_pc = abort ? 16'h0000 : {hi, lo};
        m_done = !abort;
        m_idle = 1'b1;
    endtask

    task automatic do_jmp_abort(input logic [7:0] lo, input logic [7:0] hi);
        cyc(1'b1, 3'd2, rd(), 1'b0);
        m_idle = 1'b0;
        cyc(rb(), rc(), lo, 1'b0);
        cyc(1'b1, rc(), hi, 1'b1);
        m_pc = 16'h0000;
        m_idle = 1'b1;
    endtask

    task automatic do_branch(input logic [7:0] off);
        logic [15:0] t;
        t = m_pc + {{8{off[7]}}, off};
        cyc(1'b1, 3'd3, off, 1'b0);
        if (PEN && t[15:8] != m_pc[15:8]) begin
            m_pc = {m_pc[15:8], t[7:0]};
            m_idle = 1'b0;
            cyc(rb(), rc(), rd(), 1'b0);
            m_idle = 1'b1;
        end
        m_pc = t;
        m_done = 1'b1;
    endtask

    initial begin
        n_pass = 0;
        n_tot = 0;
        chk_en = 1'b0;
        m_pc = 16'h0000;
        m_idle = 1'b1;
        m_done = 1'b0;
        m_addr_ovr = 1'b0;
        m_addr_val = 16'h0000;
        reset = 1'b1;
        cmd_valid = 1'b1;
        cmd = 3'd1;
        db_in = 8'h00;
        cyc(1'b1, 3'd1, 8'h00, 1'b1);
        chk_en = 1'b1;
        chk("reset_pc", pc_out, 16'h0000);
        chk("reset_ready", {15'd0, cmd_ready}, 16'd0);
        do_reset(2);
        do_inc();
        chk("inc1_pc", pc_out, 16'h0001);
        chk("inc1_done", {15'd0, done}, 16'd1);
        do_inc();
        chk("inc2_pc", pc_out, 16'h0002);
        do_inc();
        chk("inc3_pc", pc_out, 16'h0003);
        do_nop(3'd0);
        do_nop(3'd7);
        chk("nop_pc", pc_out, 16'h0003);
        chk("nop_done", {15'd0, done}, 16'd0);
        do_jmp(8'h34, 8'h12);
        chk("jmp_pc", pc_out, 16'h1234);
        do_vec(3'd4, 8'h00, 8'h80, 1'b0);
        chk("vec_rst_pc", pc_out, 16'h8000);
        do_vec(3'd6, 8'h55, 8'hAA, 1'b0);
        chk("vec_irq_pc", pc_out, 16'hAA55);
        do_vec(3'd5, 8'h11, 8'h22, 1'b0);
        chk("vec_nmi_pc", pc_out, 16'h2211);
        do_jmp(8'hF0, 8'h12);
        do_branch(8'h20);
        chk("br_cross_pc", pc_out, 16'h1310);
        do_jmp(8'h80, 8'h12);
        do_branch(8'hF0);
        chk("br_back_pc", pc_out, 16'h1270);
        do_jmp(8'hFF, 8'hFF);
        do_inc();
        chk("inc_wrap_pc", pc_out, 16'h0000);
        do_jmp(8'h05, 8'h00);
        do_branch(8'hF0);
        chk("br_wrap_pc", pc_out, 16'hFFF5);
        do_jmp(8'h78, 8'h56);
        do_jmp_abort(8'h34, 8'h12);
        chk("abort_pc", pc_out, 16'h0000);
        chk("abort_done", {15'd0, done}, 16'd0);
        do_reset(0);
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 7))
                0: do_nop(rb() ? 3'd0 : 3'd7);
                1: do_inc();
                2: do_jmp(rd(), rd());
                3: do_branch(rd());
                4: do_vec(3'(4 + $urandom_range(0, 2)), rd(), rd(), 1'b0);
                5: do_jmp_abort(rd(), rd());
                6: do_vec(3'(4 + $urandom_range(0, 2)), rd(), rd(), 1'b1);
                default: cyc(1'b0, rc(), rd(), 1'b0);
            endcase
        end
        cyc(1'b0, 3'd0, 8'h00, 1'b0);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
